mips_mem_access_unit: RTL and testbench
=======================================

Name: mips_mem_access_unit

Overview:
- Load/store unit between the MIPS core datapath and the data-memory bus port (wr_en / read_en / byte_en / waitrequest / data_in / data_out).
- Accepts one load/store request at a time and drives a word-aligned bus transaction with the correct lane enables.
- Holds the bus stable through waitrequest stalls and captures registered read data one cycle after bus acceptance.
- Returns sign/zero-extended or LWL/LWR-merged results to the core.

Parameters:
- TIMEOUT_CYCLES, 64, maximum consecutive waitrequest-high cycles before abort (used only with the optional feature).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  core presents a request.
- req_ready  out  1  unit idle and able to accept a request.
- req_op  in  4  0 LB, 1 LBU, 2 LH, 3 LHU, 4 LW, 5 LWL, 6 LWR, 7 SB, 8 SH, 9 SW; 10-15 reserved.
- req_addr  in  32  byte address.
- req_wdata  in  32  store source register.
- req_rt_old  in  32  current rt value, for the LWL/LWR merge.
- resp_valid  out  1  one-cycle response pulse.
- resp_data  out  32  load result; 0 for stores and errors.
- resp_error  out  1  qualifies resp_valid: misaligned address, reserved op, or timeout.
- mem_address  out  32  word-aligned bus address, {req_addr[31:2],2'b00}.
- mem_wr_en  out  1  bus write strobe.
- mem_read_en  out  1  bus read strobe.
- mem_byte_en  out  4  lane enables; lane k is bits [8k+7:8k] at byte address base+k.
- mem_waitrequest  in  1  slave stall.
- mem_wdata  out  32  lane-aligned write data.
- mem_rdata  in  32  slave read data, registered by the slave on its acceptance edge.

Behaviour:
- Reset: all outputs 0 except req_ready=1; FSM goes to IDLE.
- Reset is asynchronous. Asserting it mid-transaction drops the strobes immediately; no response is issued.
- Request acceptance: a request is taken at a rising edge where req_valid & req_ready. All request fields are latched on that edge.
- States:
  - IDLE: req_ready=1.
  - BUS: strobe asserted; address, byte_en and wdata held constant.
  - RDCAP: captures mem_rdata.
  - RESP: resp_valid=1 for exactly one cycle, then back to IDLE.
- Transitions:
  - IDLE->BUS on acceptance with a legal op and aligned address.
  - IDLE->RESP on a misaligned address or reserved op, with resp_error=1 and no bus activity.
  - BUS holds while mem_waitrequest=1.
  - On an edge with the strobe high and mem_waitrequest=0, the bus transaction is accepted: the strobe drops next cycle; a store goes to RESP, a load goes to RDCAP.
  - RDCAP->RESP unconditionally.
- Alignment rules: LH/LHU/SH require addr[0]=0; LW/SW require addr[1:0]=0; byte ops, LWL and LWR are never misaligned.
- Latency with no stalls, counting the acceptance cycle as N:
  - Strobe high in N+1.
  - Store resp_valid in N+2.
  - Load resp_valid in N+3.
  - Each waitrequest-high cycle adds one cycle.
  - Error response in N+1.
- Store lanes, with o = addr[1:0]:
  - SB: byte_en = 1<<o; wdata = byte replicated on all four lanes.
  - SH: byte_en = 0011 or 1100; wdata = halfword replicated.
  - SW: byte_en = 1111.
- Loads: byte_en = 1111, read_en=1.
  - LB/LBU: select lane o, then sign- or zero-extend.
  - LH/LHU: select lanes o..o+1, then extend.
  - LW: full word.
  - LWL: (rdata << 8*(3-o)) | (rt_old & ((1<<8*(3-o))-1)).
  - LWR: (rdata >> 8*o) | (rt_old & ~(32'hFFFFFFFF >> 8*o)).
- mem_wr_en and mem_read_en are never high together.
- Outputs are registered; no combinational path from req_* to mem_*.

Optional Feature:
- Macro: MEM_TIMEOUT_EN.
- When defined: a counter counts consecutive BUS cycles with mem_waitrequest=1. When it reaches TIMEOUT_CYCLES, the strobes drop and the FSM goes to RESP with resp_error=1 and resp_data=0.
- When undefined: no counter is present and the unit waits on waitrequest indefinitely.

Test Plan:
- SW addr 0x100, wdata 0x11223344, waitrequest low -> strobe in N+1 with byte_en 1111 and mem_wdata 0x11223344; resp_valid in N+2, resp_error=0.
- LB addr 0x103 with memory word 0x80AA5500, then LBU at the same address -> resp_data 0xFFFFFF80, then 0x00000080; each resp_valid in N+3.
- SH addr 0x102, wdata 0x0000BEEF -> byte_en 1100, mem_wdata 0xBEEFBEEF. Then LW 0x100 -> 0xBEEFxxxx with the lower half unchanged.
- LWL addr 0x101 with word 0xDDCCBBAA and rt_old 0x12345678 -> 0xBBAA5678. LWR addr 0x101 with the same inputs -> 0x12DDCCBB.
- LW addr 0x102 -> no strobe at any point; resp_valid in N+1 with resp_error=1 and resp_data=0.
- LW with waitrequest high for 5 cycles -> address and read_en stable throughout; resp_valid in N+8. With MEM_TIMEOUT_EN and TIMEOUT_CYCLES=4, waitrequest held high -> resp_error=1. rst_n pulsed during BUS -> strobes drop immediately, req_ready=1, no response.

Source files
------------

// File: rtl/mips_mem_access_unit_if.sv
// Signal bundle for mips_mem_access_unit. The master modport is the unit itself:
// it answers core requests and drives the data-memory bus.
interface mips_mem_access_unit_if;
  logic        req_valid;
  logic        req_ready;
  logic [3:0]  req_op;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [31:0] req_rt_old;
  logic        resp_valid;
  logic [31:0] resp_data;
  logic        resp_error;
  logic [31:0] mem_address;
  logic        mem_wr_en;
  logic        mem_read_en;
  logic [3:0]  mem_byte_en;
  logic        mem_waitrequest;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  modport master (
    input  req_valid, req_op, req_addr, req_wdata, req_rt_old,
    output req_ready, resp_valid, resp_data, resp_error,
    output mem_address, mem_wr_en, mem_read_en, mem_byte_en, mem_wdata,
    input  mem_waitrequest, mem_rdata
  );

  modport slave (
    output req_valid, req_op, req_addr, req_wdata, req_rt_old,
    input  req_ready, resp_valid, resp_data, resp_error,
    input  mem_address, mem_wr_en, mem_read_en, mem_byte_en, mem_wdata,
    output mem_waitrequest, mem_rdata
  );
endinterface

// File: rtl/mips_mem_access_unit.sv
// MIPS load/store unit: one request at a time, word-aligned bus access, load extension/merge.
// Define MEM_TIMEOUT_EN to abort bus accesses stalled for TIMEOUT_CYCLES consecutive cycles.
module mips_mem_access_unit #(
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input logic                    clk,
  input logic                    rst_n,
  mips_mem_access_unit_if.master bus
);

  typedef enum logic [1:0] {IDLE, BUS, RDCAP, RESP} state_t;

  localparam logic [3:0] OP_LB  = 4'd0;
  localparam logic [3:0] OP_LBU = 4'd1;
  localparam logic [3:0] OP_LH  = 4'd2;
  localparam logic [3:0] OP_LHU = 4'd3;
  localparam logic [3:0] OP_LW  = 4'd4;
  localparam logic [3:0] OP_LWL = 4'd5;
  localparam logic [3:0] OP_LWR = 4'd6;
  localparam logic [3:0] OP_SB  = 4'd7;
  localparam logic [3:0] OP_SH  = 4'd8;
  localparam logic [3:0] OP_SW  = 4'd9;

  if (TIMEOUT_CYCLES == 0) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 1");
  end

  state_t      state_q, state_d;
  logic [3:0]  op_q, op_d;
  logic [1:0]  off_q, off_d;
  logic [31:0] rt_old_q, rt_old_d;
  logic [31:0] mem_address_q, mem_address_d;
  logic        mem_wr_en_q, mem_wr_en_d;
  logic        mem_read_en_q, mem_read_en_d;
  logic [3:0]  mem_byte_en_q, mem_byte_en_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic        resp_valid_q, resp_valid_d;
  logic        resp_error_q, resp_error_d;
  logic [31:0] resp_data_q, resp_data_d;

  logic        req_illegal;
  logic        timeout_hit;
  logic [31:0] load_result;
  logic [31:0] rd_shr;
  logic [4:0]  sh_lo;
  logic [4:0]  sh_hi;

`ifdef MEM_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] to_cnt_q, to_cnt_d;

  always_comb begin
    to_cnt_d = '0;
    if (state_q == BUS && bus.mem_waitrequest) begin
      to_cnt_d = to_cnt_q + 1'b1;
    end
  end

  // Fires on the TIMEOUT_CYCLES-th consecutive stalled cycle.
  assign timeout_hit = (state_q == BUS) && bus.mem_waitrequest &&
                       (to_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      to_cnt_q <= '0;
    end else begin
      to_cnt_q <= to_cnt_d;
    end
  end
`else
  assign timeout_hit = 1'b0;
`endif

  always_comb begin
    req_illegal = 1'b0;
    case (bus.req_op)
      OP_LH, OP_LHU, OP_SH:                      req_illegal = bus.req_addr[0];
      OP_LW, OP_SW:                              req_illegal = |bus.req_addr[1:0];
      OP_LB, OP_LBU, OP_LWL, OP_LWR, OP_SB:      req_illegal = 1'b0;
      default:                                   req_illegal = 1'b1;
    endcase
  end

  // mem_rdata is valid in RDCAP; lane o is brought down to bits [7:0] first.
  always_comb begin
    sh_lo  = {off_q, 3'b000};
    sh_hi  = {~off_q, 3'b000};
    rd_shr = bus.mem_rdata >> sh_lo;
    case (op_q)
      OP_LB:   load_result = {{24{rd_shr[7]}}, rd_shr[7:0]};
      OP_LBU:  load_result = {24'h0, rd_shr[7:0]};
      OP_LH:   load_result = {{16{rd_shr[15]}}, rd_shr[15:0]};
      OP_LHU:  load_result = {16'h0, rd_shr[15:0]};
      OP_LWL:  load_result = (bus.mem_rdata << sh_hi) |
                             (rt_old_q & ((32'd1 << sh_hi) - 32'd1));
      OP_LWR:  load_result = rd_shr | (rt_old_q & ~(32'hFFFF_FFFF >> sh_lo));
      default: load_result = bus.mem_rdata;
    endcase
  end

  always_comb begin
    state_d       = state_q;
    op_d          = op_q;
    off_d         = off_q;
    rt_old_d      = rt_old_q;
    mem_address_d = mem_address_q;
    mem_wr_en_d   = mem_wr_en_q;
    mem_read_en_d = mem_read_en_q;
    mem_byte_en_d = mem_byte_en_q;
    mem_wdata_d   = mem_wdata_q;
    resp_valid_d  = 1'b0;
    resp_error_d  = 1'b0;
    resp_data_d   = 32'h0;

    case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          op_d     = bus.req_op;
          off_d    = bus.req_addr[1:0];
          rt_old_d = bus.req_rt_old;
          if (req_illegal) begin
            state_d      = RESP;
            resp_valid_d = 1'b1;
            resp_error_d = 1'b1;
          end else begin
            state_d       = BUS;
            mem_address_d = {bus.req_addr[31:2], 2'b00};
            case (bus.req_op)
              OP_SB: begin
                mem_wr_en_d   = 1'b1;
                mem_byte_en_d = 4'b0001 << bus.req_addr[1:0];
                mem_wdata_d   = {4{bus.req_wdata[7:0]}};
              end
              OP_SH: begin
                mem_wr_en_d   = 1'b1;
                mem_byte_en_d = bus.req_addr[1] ? 4'b1100 : 4'b0011;
                mem_wdata_d   = {2{bus.req_wdata[15:0]}};
              end
              OP_SW: begin
                mem_wr_en_d   = 1'b1;
                mem_byte_en_d = 4'b1111;
                mem_wdata_d   = bus.req_wdata;
              end
              default: begin
                mem_read_en_d = 1'b1;
                mem_byte_en_d = 4'b1111;
              end
            endcase
          end
        end
      end

      BUS: begin
        if (!bus.mem_waitrequest) begin
          mem_wr_en_d   = 1'b0;
          mem_read_en_d = 1'b0;
          if (op_q <= OP_LWR) begin
            state_d = RDCAP;
          end else begin
            state_d      = RESP;
            resp_valid_d = 1'b1;
          end
        end else if (timeout_hit) begin
          mem_wr_en_d   = 1'b0;
          mem_read_en_d = 1'b0;
          state_d       = RESP;
          resp_valid_d  = 1'b1;
          resp_error_d  = 1'b1;
        end
      end

      RDCAP: begin
        state_d      = RESP;
        resp_valid_d = 1'b1;
        resp_data_d  = load_result;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      op_q          <= 4'h0;
      off_q         <= 2'b00;
      rt_old_q      <= 32'h0;
      mem_address_q <= 32'h0;
      mem_wr_en_q   <= 1'b0;
      mem_read_en_q <= 1'b0;
      mem_byte_en_q <= 4'h0;
      mem_wdata_q   <= 32'h0;
      resp_valid_q  <= 1'b0;
      resp_error_q  <= 1'b0;
      resp_data_q   <= 32'h0;
    end else begin
      state_q       <= state_d;
      op_q          <= op_d;
      off_q         <= off_d;
      rt_old_q      <= rt_old_d;
      mem_address_q <= mem_address_d;
      mem_wr_en_q   <= mem_wr_en_d;
      mem_read_en_q <= mem_read_en_d;
      mem_byte_en_q <= mem_byte_en_d;
      mem_wdata_q   <= mem_wdata_d;
      resp_valid_q  <= resp_valid_d;
      resp_error_q  <= resp_error_d;
      resp_data_q   <= resp_data_d;
    end
  end

  assign bus.req_ready   = (state_q == IDLE);
  assign bus.resp_valid  = resp_valid_q;
  assign bus.resp_error  = resp_error_q;
  assign bus.resp_data   = resp_data_q;
  assign bus.mem_address = mem_address_q;
  assign bus.mem_wr_en   = mem_wr_en_q;
  assign bus.mem_read_en = mem_read_en_q;
  assign bus.mem_byte_en = mem_byte_en_q;
  assign bus.mem_wdata   = mem_wdata_q;

endmodule

// File: tb/tb_mips_mem_access_unit.sv
// Bench for mips_mem_access_unit: directed plan items plus random requests,
// checked against a byte-addressed reference memory model.
module tb_mips_mem_access_unit;

`ifdef MEM_TIMEOUT_EN
  localparam int TO    = 4;
  localparam bit TO_EN = 1'b1;
`else
  localparam int TO    = 64;
  localparam bit TO_EN = 1'b0;
`endif

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  mips_mem_access_unit_if bus ();

  mips_mem_access_unit #(.TIMEOUT_CYCLES(TO)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference memory: 256 bytes, little-endian, addressed by addr[7:0].
  logic [7:0]  ref_bytes [0:255];
  logic [31:0] slave_mem [0:63];
  int          stall_req;
  int          stall_done;

  // Bus slave: stalls stall_req cycles per access, registers read data on acceptance.
  always @(posedge clk) begin
    if (!rst_n) begin
      for (int w = 0; w < 64; w++)
        slave_mem[w] <= {ref_bytes[4*w+3], ref_bytes[4*w+2], ref_bytes[4*w+1], ref_bytes[4*w]};
      stall_done <= 0;
    end else if (bus.mem_wr_en || bus.mem_read_en) begin
      if (stall_done < stall_req) begin
        stall_done <= stall_done + 1;
      end else begin
        if (bus.mem_read_en) bus.mem_rdata <= slave_mem[bus.mem_address[7:2]];
        for (int k = 0; k < 4; k++)
          if (bus.mem_wr_en && bus.mem_byte_en[k])
            slave_mem[bus.mem_address[7:2]][8*k +: 8] <= bus.mem_wdata[8*k +: 8];
      end
    end else begin
      stall_done <= 0;
    end
  end

  assign bus.mem_waitrequest = (stall_done < stall_req);

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] rb(input logic [31:0] a);
    return ref_bytes[a[7:0]];
  endfunction

  task automatic do_req(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [31:0] rt, input int stalls, output logic [31:0] got);
    int          oi, size, exp_lat, strobe_first, resp_cyc;
    logic [31:0] base, exp_data, exp_wd, s_addr, s_wd;
    logic [3:0]  exp_be, s_be;
    logic [7:0]  b;
    logic [15:0] h;
    logic        s_wr, s_rd, got_err;
    bit          is_load, is_store, err, tmo, stable_ok, excl_ok;

    oi       = int'(addr[1:0]);
    base     = {addr[31:2], 2'b00};
    is_load  = (op <= 4'd6);
    is_store = (op >= 4'd7) && (op <= 4'd9);
    size     = (op == 4'd0 || op == 4'd1 || op == 4'd7) ? 1 :
               (op == 4'd2 || op == 4'd3 || op == 4'd8) ? 2 : 4;
    err      = !(is_load || is_store) || (size == 2 && addr[0]) ||
               ((op == 4'd4 || op == 4'd9) && oi != 0);
    tmo      = TO_EN && !err && stalls >= TO;

    exp_be   = 4'b1111;
    exp_wd   = 32'h0;
    exp_data = 32'h0;
    if (is_store) begin
      exp_be = 4'b0000;
      for (int k = 0; k < size; k++) exp_be[oi + k] = 1'b1;
      exp_wd = (size == 1) ? {4{wdata[7:0]}} : (size == 2) ? {2{wdata[15:0]}} : wdata;
    end
    case (op)
      4'd0: begin b = rb(addr); exp_data = {{24{b[7]}}, b}; end
      4'd1: exp_data = {24'h0, rb(addr)};
      4'd2: begin h = {rb(addr + 1), rb(addr)}; exp_data = {{16{h[15]}}, h}; end
      4'd3: exp_data = {16'h0, rb(addr + 1), rb(addr)};
      4'd4: exp_data = {rb(addr + 3), rb(addr + 2), rb(addr + 1), rb(addr)};
      4'd5: begin
        exp_data = rt;
        for (int k = 0; k <= oi; k++) exp_data[8*(3 - oi + k) +: 8] = rb(base + 32'(k));
      end
      4'd6: begin
        exp_data = rt;
        for (int k = oi; k < 4; k++) exp_data[8*(k - oi) +: 8] = rb(base + 32'(k));
      end
      default: exp_data = 32'h0;
    endcase
    if (err || tmo) exp_data = 32'h0;
    exp_lat = err ? 1 : tmo ? TO + 1 : is_store ? 2 + stalls : 3 + stalls;

    stall_req = stalls;
    @(negedge clk);
    bus.req_op     = op;
    bus.req_addr   = addr;
    bus.req_wdata  = wdata;
    bus.req_rt_old = rt;
    bus.req_valid  = 1'b1;
    check("req_ready", 32'(bus.req_ready), 32'd1);
    @(posedge clk);
    #1 bus.req_valid = 1'b0;

    strobe_first = -1;
    resp_cyc     = -1;
    stable_ok    = 1'b1;
    excl_ok      = 1'b1;
    got          = 32'h0;
    got_err      = 1'b0;
    s_addr = 32'h0; s_wd = 32'h0; s_be = 4'h0; s_wr = 1'b0; s_rd = 1'b0;
    for (int k = 1; k <= 60 && resp_cyc < 0; k++) begin
      @(negedge clk);
      if (bus.mem_wr_en || bus.mem_read_en) begin
        if (strobe_first < 0) begin
          strobe_first = k;
          s_addr = bus.mem_address; s_be = bus.mem_byte_en; s_wd = bus.mem_wdata;
          s_wr = bus.mem_wr_en;     s_rd = bus.mem_read_en;
        end else if (bus.mem_address !== s_addr || bus.mem_byte_en !== s_be ||
                     bus.mem_wdata !== s_wd || bus.mem_wr_en !== s_wr || bus.mem_read_en !== s_rd) begin
          stable_ok = 1'b0;
        end
      end
      if (bus.mem_wr_en && bus.mem_read_en) excl_ok = 1'b0;
      if (bus.resp_valid) begin
        resp_cyc = k;
        got      = bus.resp_data;
        got_err  = bus.resp_error;
      end
    end

    check("latency", 32'(resp_cyc), 32'(exp_lat));
    check("resp_error", 32'(got_err), 32'(err || tmo));
    check("resp_data", got, exp_data);
    check("strobe_exclusive", 32'(excl_ok), 32'd1);
    if (err) begin
      check("no_strobe", 32'(strobe_first), 32'hFFFF_FFFF);
    end else begin
      check("strobe_cycle", 32'(strobe_first), 32'd1);
      check("mem_address", s_addr, base);
      check("byte_en", 32'(s_be), 32'(exp_be));
      check("strobe_kind", 32'({s_wr, s_rd}), is_store ? 32'd2 : 32'd1);
      check("bus_stable", 32'(stable_ok), 32'd1);
      if (is_store) check("mem_wdata", s_wd, exp_wd);
    end

    @(negedge clk);
    check("resp_one_cycle", 32'(bus.resp_valid), 32'd0);
    check("ready_back", 32'(bus.req_ready), 32'd1);

    if (is_store && !err && !tmo)
      for (int k = 0; k < size; k++) ref_bytes[8'(addr + 32'(k))] = wdata[8*k +: 8];

    $display("txn op=%0d addr=%08h wdata=%08h rt=%08h stalls=%0d -> data=%08h err=%0b lat=%0d",
             op, addr, wdata, rt, stalls, got, got_err, resp_cyc);
  endtask

  initial begin
    logic [31:0] got;
    int          seen;
    checks         = 0;
    errors         = 0;
    stall_req      = 0;
    rst_n          = 1'b0;
    bus.req_valid  = 1'b0;
    bus.req_op     = 4'h0;
    bus.req_addr   = 32'h0;
    bus.req_wdata  = 32'h0;
    bus.req_rt_old = 32'h0;
    for (int i = 0; i < 256; i++) ref_bytes[i] = 8'($urandom);

    #3;
    check("rst_req_ready", 32'(bus.req_ready), 32'd1);
    check("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
    check("rst_strobes", 32'({bus.mem_wr_en, bus.mem_read_en}), 32'd0);
    check("rst_byte_en", 32'(bus.mem_byte_en), 32'd0);
    check("rst_address", bus.mem_address, 32'h0);
    check("rst_resp_data", bus.resp_data, 32'h0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    do_req(4'd9, 32'h0000_0100, 32'h1122_3344, 32'h0, 0, got);
    do_req(4'd9, 32'h0000_0100, 32'h80AA_5500, 32'h0, 0, got);
    do_req(4'd0, 32'h0000_0103, 32'h0, 32'h0, 0, got);
    check("plan_lb", got, 32'hFFFF_FF80);
    do_req(4'd1, 32'h0000_0103, 32'h0, 32'h0, 0, got);
    check("plan_lbu", got, 32'h0000_0080);
    do_req(4'd8, 32'h0000_0102, 32'h0000_BEEF, 32'h0, 0, got);
    do_req(4'd4, 32'h0000_0100, 32'h0, 32'h0, 0, got);
    check("plan_lw_after_sh", got, 32'hBEEF_5500);
    do_req(4'd9, 32'h0000_0100, 32'hDDCC_BBAA, 32'h0, 0, got);
    do_req(4'd5, 32'h0000_0101, 32'h0, 32'h1234_5678, 0, got);
    check("plan_lwl", got, 32'hBBAA_5678);
    do_req(4'd6, 32'h0000_0101, 32'h0, 32'h1234_5678, 0, got);
    check("plan_lwr", got, 32'h12DD_CCBB);
    do_req(4'd4, 32'h0000_0102, 32'h0, 32'h0, 0, got);
    check("plan_misaligned_data", got, 32'h0);
    do_req(4'd4, 32'h0000_0100, 32'h0, 32'h0, 5, got);
    check("plan_lw_stall5", got, TO_EN ? 32'h0 : 32'hDDCC_BBAA);
`ifdef MEM_TIMEOUT_EN
    do_req(4'd4, 32'h0000_0104, 32'h0, 32'h0, 100, got);
    check("plan_timeout_data", got, 32'h0);
`endif
    do_req(4'd12, 32'h0000_0010, 32'h0, 32'h0, 0, got);

    // Reset in the middle of a stalled load: strobes drop at once, nothing is answered.
    stall_req = 10;
    @(negedge clk);
    bus.req_op    = 4'd4;
    bus.req_addr  = 32'h0000_0040;
    bus.req_valid = 1'b1;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_mid_pre_strobe", 32'(bus.mem_read_en), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("rst_mid_strobes", 32'({bus.mem_wr_en, bus.mem_read_en}), 32'd0);
    check("rst_mid_ready", 32'(bus.req_ready), 32'd1);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    stall_req = 0;
    seen = 0;
    repeat (6) begin
      @(negedge clk);
      if (bus.resp_valid) seen++;
    end
    check("rst_mid_no_resp", 32'(seen), 32'd0);

    for (int n = 0; n < 40; n++) begin
      do_req(4'($urandom_range(0, 15)), $urandom, $urandom, $urandom, int'($urandom_range(0, 3)), got);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
